// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Entry layout matches what decode consumes: the PC alongside its instruction word.
// No logic beyond a word-align helper.
package riscv_fetch_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO of fetch entries, flush has priority over push and pop.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push while full is accepted only together with a pop.
module riscv_fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_dat,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: sequential PC generation, credit-limited imem requests, buffered in-order responses.
// Latency: response in cycle N reaches inst_valid_o in cycle N+1 (no bypass).
// Backpressure: decode stalls fill the buffer, which withholds request credit; responses are never stalled.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = CW + 1;
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
    fetch_entry_t  fifo_head, fifo_push_dat;
    logic          req_fire, resp_drop, resp_take;
    logic [SW-1:0] credit_used;
    logic [IW-1:0] inflight;
    logic          unused_full;

    // outstanding counts live requests only; requests orphaned by a redirect move into drop_cnt,
    // so the two are disjoint and their sum with the buffer fill never exceeds FIFO_DEPTH.
    assign credit_used    = SW'(outstanding_q) + SW'(fifo_count) + SW'(drop_cnt_q);
    assign imem_req_valid = rst_n && !redirect_valid && (credit_used < SW'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop     = imem_resp_valid && (drop_cnt_q != '0);
    assign resp_take     = imem_resp_valid && !resp_drop;
    assign fifo_push     = resp_take && !redirect_valid;
    assign fifo_pop      = !fifo_empty && inst_ready_i && !redirect_valid;
    assign fifo_push_dat = '{pc: resp_pc_q, inst: imem_resp_data};

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? INST_NOP : fifo_head.inst;
    assign pc_o         = fifo_empty ? 32'h0    : fifo_head.pc;
    assign unused_full  = fifo_full;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        inflight      = IW'(outstanding_q) + IW'(drop_cnt_q);
        if (redirect_valid) begin
            fetch_pc_d    = word_align(redirect_pc);
            resp_pc_d     = word_align(redirect_pc);
            outstanding_d = '0;
            drop_cnt_d    = CW'(inflight - IW'(imem_resp_valid && (inflight != '0)));
        end else begin
            if (req_fire)  fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_take) resp_pc_d  = resp_pc_q + 32'd4;
            if (resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
            outstanding_d = outstanding_q + CW'(req_fire)
                          - CW'(resp_take && (outstanding_q != '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    riscv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (redirect_valid),
        .push_dat (fifo_push_dat),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: instruction memory model answers addr|0x13 after a programmable delay,
// a scoreboard queue holds the expected {pc, inst} stream and a monitor checks every decode handshake.
module tb_riscv_fetch;
    import riscv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid_o, inst_ready_i;
    logic [31:0] inst_o, pc_o;

    riscv_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .pc_o            (pc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed { int due; logic [31:0] data; } mem_rsp_t;
    mem_rsp_t     mq[$];
    fetch_entry_t exp_q[$];
    int total = 0, bad = 0, cyc = 0, mem_lat = 1, accepted = 0, pops = 0;
    logic        fire_nxt;
    logic [31:0] addr_nxt;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            exp_q.push_back('{pc: a, inst: a | 32'h13});
        end
    endtask

    task automatic do_reset(input int lat);
        rst_n   = 1'b0;
        mem_lat = lat;
        step();
        step();
        exp_q.delete();
        push_exp(32'h0, 64);
        accepted = 0;
        pops     = 0;
        rst_n    = 1'b1;
        #1;
    endtask

    // Memory: request seen at the edge of cycle c is answered in cycle c+mem_lat-1.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            fire_nxt = rst_n && imem_req_valid && imem_req_ready;
            addr_nxt = imem_req_addr;
            @(posedge clk);
            cyc++;
            if (!rst_n) mq.delete();
            else if (fire_nxt) begin
                mq.push_back('{due: cyc + mem_lat - 1, data: addr_nxt | 32'h13});
                accepted++;
            end
            #1;
            if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_resp_data  = mq[0].data;
                void'(mq.pop_front());
                imem_resp_valid = 1'b1;
            end else begin
                imem_resp_valid = 1'b0;
            end
        end
    end

    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !redirect_valid && inst_valid_o && inst_ready_i) begin
                pops++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: pc_o=%h inst_o=%h with nothing expected", pc_o, inst_o);
                end else begin
                    e = exp_q.pop_front();
                    check32("sb_pc", pc_o, e.pc);
                    check32("sb_inst", inst_o, e.inst);
                end
            end
            if (rst_n && dut.fifo_full && dut.fifo_push && !dut.fifo_pop && !redirect_valid) begin
                bad++;
                $display("FAIL fifo_overflow: push into full buffer without pop");
            end
            if (rst_n && imem_resp_valid && dut.outstanding_q == '0 && dut.drop_cnt_q == '0) begin
                bad++;
                $display("FAIL unsolicited_resp: response with nothing outstanding");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready_i   = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_inst_valid", inst_valid_o, 1'b0);
        check32("rst_pc", pc_o, 32'h0);
        check32("rst_inst", inst_o, 32'h13);

        // Streaming from reset with 1-cycle memory.
        do_reset(1);
        check1("t1_req_valid", imem_req_valid, 1'b1);
        check32("t1_req_addr0", imem_req_addr, 32'h0);
        step();
        check1("t1_no_bypass", inst_valid_o, 1'b0);
        check32("t1_req_addr1", imem_req_addr, 32'h4);
        step();
        check1("t1_first_valid", inst_valid_o, 1'b1);
        check32("t1_first_pc", pc_o, 32'h0);
        check32("t1_first_inst", inst_o, 32'h13);
        repeat (30) step();
        check1("t1_throughput", pops >= 15, 1'b1);

        // Decode stall: credit caps requests, head holds.
        inst_ready_i = 1'b0;
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            step();
            check1("t2_credit_cap", (accepted - pops) <= 2, 1'b1);
        end
        check32("t2_accepted", 32'(accepted), 32'd2);
        check1("t2_hold_valid", inst_valid_o, 1'b1);
        check32("t2_hold_pc", pc_o, 32'h0);
        check32("t2_hold_inst", inst_o, 32'h13);
        inst_ready_i = 1'b1;
        repeat (12) step();
        check1("t2_resume", pops >= 6, 1'b1);

        // Redirect with two requests (0x8, 0xC) in flight.
        do_reset(3);
        for (int i = 0; i < 40 && !(mq.size() == 2 && !imem_resp_valid && pops == 2); i++) step();
        check1("t3_two_inflight", mq.size() == 2 && !imem_resp_valid && pops == 2, 1'b1);
        check32("t3_inflight_head", mq[0].data, 32'h1B);
        exp_q.delete();
        push_exp(32'h100, 32);
        redirect_pc    = 32'h100;
        redirect_valid = 1'b1;
        #1;
        check1("t3_no_req_on_redirect", imem_req_valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        #1;
        check1("t3_flushed", inst_valid_o, 1'b0);
        for (int i = 0; i < 40 && !imem_req_valid; i++) step();
        check32("t3_new_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 40 && !inst_valid_o; i++) step();
        check32("t3_new_pc", pc_o, 32'h100);
        repeat (6) step();

        // Redirect coinciding with a response, unaligned target.
        do_reset(1);
        for (int i = 0; i < 40 && !(imem_resp_valid && pops >= 2); i++) step();
        check1("t4_resp_present", imem_resp_valid && pops >= 2, 1'b1);
        exp_q.delete();
        push_exp(32'h200, 32);
        redirect_pc    = 32'h203;
        redirect_valid = 1'b1;
        #1;
        check1("t4_no_req_on_redirect", imem_req_valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        #1;
        check1("t4_flushed", inst_valid_o, 1'b0);
        for (int i = 0; i < 40 && !imem_req_valid; i++) step();
        check32("t4_new_addr", imem_req_addr, 32'h200);
        for (int i = 0; i < 40 && !inst_valid_o; i++) step();
        check32("t4_new_pc", pc_o, 32'h200);
        check32("t4_new_inst", inst_o, 32'h213);
        repeat (6) step();

        // Back-to-back redirects: 0x40 then 0x80, last one wins.
        do_reset(2);
        for (int i = 0; i < 40 && pops < 1; i++) step();
        exp_q.delete();
        redirect_pc    = 32'h40;
        redirect_valid = 1'b1;
        step();
        push_exp(32'h80, 32);
        redirect_pc = 32'h80;
        #1;
        check1("t5_no_req_second", imem_req_valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 40 && !inst_valid_o; i++) step();
        check32("t5_first_pc", pc_o, 32'h80);
        check32("t5_first_inst", inst_o, 32'h93);
        repeat (8) step();

        // Asynchronous reset with a request outstanding.
        do_reset(3);
        for (int i = 0; i < 40 && !(pops >= 1 && mq.size() > 0); i++) step();
        check1("t6_outstanding", pops >= 1 && mq.size() > 0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check1("t6_req_valid", imem_req_valid, 1'b0);
        check1("t6_inst_valid", inst_valid_o, 1'b0);
        check32("t6_pc", pc_o, 32'h0);
        check32("t6_inst", inst_o, 32'h13);
        do_reset(3);
        check1("t6_restart_valid", imem_req_valid, 1'b1);
        check32("t6_restart_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 40 && !inst_valid_o; i++) step();
        check32("t6_first_pc", pc_o, 32'h0);
        repeat (10) step();
        check1("t6_stream", pops >= 3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
